// File: rtl/snn_window_classifier_pkg.sv
// Shared types, default neuron constants and width helpers for the spiking classifier.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_ARGMAX = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_THRESHOLD = 16;
    localparam int DEF_THR_INC   = 4;
    localparam int DEF_THR_DEC   = 2;
    localparam int DEF_THR_MIN   = 8;

    // Index width for a table of n entries, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of an unweighted-sum current: holds n_in weights without truncation.
    function automatic int cur_w(input int n_in, input int w_w);
        return w_w + $clog2(n_in);
    endfunction

endpackage

// File: rtl/snn_window_classifier_if.sv
// Control, weight-write and result signals of the window classifier.
interface snn_window_classifier_if import snn_pkg::*; #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 10,
    parameter int W_W   = 3,
    parameter int CNT_W = 8
);
    localparam int NA = idx_w(N_OUT);
    localparam int IA = idx_w(N_IN);

    logic             start_i;
    logic [N_IN-1:0]  spike_i;
    logic             wr_en_i;
    logic [NA-1:0]    wr_neuron_i;
    logic [IA-1:0]    wr_input_i;
    logic [W_W-1:0]   wr_data_i;
    logic             busy_o;
    logic [N_OUT-1:0] spike_o;
    logic             result_valid_o;
    logic [NA-1:0]    class_o;
    logic [CNT_W-1:0] max_count_o;

    modport slave (
        input  start_i, spike_i, wr_en_i, wr_neuron_i, wr_input_i, wr_data_i,
        output busy_o, spike_o, result_valid_o, class_o, max_count_o
    );

    modport master (
        output start_i, spike_i, wr_en_i, wr_neuron_i, wr_input_i, wr_data_i,
        input  busy_o, spike_o, result_valid_o, class_o, max_count_o
    );

endinterface

// File: rtl/snn_window_classifier_lif_neuron.sv
// Leaky integrate-and-fire neuron with adaptive threshold and saturating spike counter.
module lif_neuron #(
    parameter int POT_W      = 8,
    parameter int CNT_W      = 8,
    parameter int CUR_W      = 6,
    parameter int LEAK_SHIFT = 3,
    parameter int THRESHOLD  = 16,
    parameter int THR_INC    = 4,
    parameter int THR_DEC    = 2,
    parameter int THR_MIN    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CUR_W-1:0] cur_i,
    output logic             spike_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int SUM_W = ((POT_W > CUR_W) ? POT_W : CUR_W) + 1;
    localparam logic [POT_W-1:0] POT_MAX = '1;

    logic [POT_W-1:0] v_q, thr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             spike_q;
    logic [POT_W-1:0] v_leak, v_n, thr_inc_sat, thr_dec_flr;
    logic [SUM_W-1:0] sum;
    logic [POT_W:0]   thr_up;
    logic             fire;

    // Next potential, fire decision and both threshold update candidates.
    always_comb begin
        v_leak      = v_q - (v_q >> LEAK_SHIFT);
        sum         = SUM_W'(v_leak) + SUM_W'(cur_i);
        v_n         = (sum > SUM_W'(POT_MAX)) ? POT_MAX : sum[POT_W-1:0];
        fire        = en_i && (v_n >= thr_q);
        thr_up      = {1'b0, thr_q} + (POT_W+1)'(THR_INC);
        thr_inc_sat = thr_up[POT_W] ? POT_MAX : thr_up[POT_W-1:0];
        thr_dec_flr = (32'(thr_q) >= 32'(THR_MIN + THR_DEC)) ? (thr_q - POT_W'(THR_DEC))
                                                             : POT_W'(THR_MIN);
    end

    // Neuron state: cleared on reset/window start, updated only while enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            v_q     <= '0;
            thr_q   <= POT_W'(THRESHOLD);
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            spike_q <= fire;
            if (en_i) begin
                if (fire) begin
                    v_q   <= '0;
                    thr_q <= thr_inc_sat;
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                end else begin
                    v_q   <= v_n;
                    thr_q <= thr_dec_flr;
                end
            end
        end
    end

    assign spike_o = spike_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/snn_window_classifier.sv
// Windowed spiking classifier: weight matrix, current adders, FSM and argmax scan.
module snn_window_classifier import snn_pkg::*; #(
    parameter int N_IN       = 8,
    parameter int N_OUT      = 10,
    parameter int W_W        = 3,
    parameter int POT_W      = 8,
    parameter int CNT_W      = 8,
    parameter int WIN_LEN    = 64,
    parameter int LEAK_SHIFT = 3,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int THR_INC    = DEF_THR_INC,
    parameter int THR_DEC    = DEF_THR_DEC,
    parameter int THR_MIN    = DEF_THR_MIN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    snn_window_classifier_if.slave bus
);
    localparam int NA    = idx_w(N_OUT);
    localparam int CUR_W = cur_w(N_IN, W_W);
    localparam int WC_W  = idx_w(WIN_LEN);

    state_t state_q, state_d;

    logic [N_OUT-1:0][N_IN-1:0][W_W-1:0] w_q;
    logic [N_OUT-1:0][CUR_W-1:0]         cur;
    logic [N_OUT-1:0][CNT_W-1:0]         cnt;
    logic [N_OUT-1:0]                    spk;

    logic [WC_W-1:0]  win_cnt_q;
    logic [NA-1:0]    scan_idx_q;
    logic [NA-1:0]    best_idx_q;
    logic [CNT_W-1:0] best_cnt_q;

    logic [31:0] wn_ext, wi_ext;
    logic        last_win, last_scan;
    logic        clear, neuron_en, wr_ok, busy, valid;

    assign wn_ext    = 32'(bus.wr_neuron_i);
    assign wi_ext    = 32'(bus.wr_input_i);
    assign last_win  = (32'(win_cnt_q) == 32'(WIN_LEN - 1));
    assign last_scan = (32'(scan_idx_q) == 32'(N_OUT - 1));

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.start_i) state_d = ST_RUN;
            ST_RUN:    if (last_win)    state_d = ST_ARGMAX;
            ST_ARGMAX: if (last_scan)   state_d = ST_DONE;
            ST_DONE:                    state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        clear     = (state_q == ST_IDLE) && bus.start_i;
        neuron_en = (state_q == ST_RUN);
        busy      = (state_q == ST_RUN) || (state_q == ST_ARGMAX);
        valid     = (state_q == ST_DONE);
        wr_ok     = (state_q == ST_IDLE) && bus.wr_en_i &&
                    (wn_ext < 32'(N_OUT)) && (wi_ext < 32'(N_IN));
    end

    // Weight matrix; a write in the start cycle lands before the first RUN update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_q <= '0;
        end else if (wr_ok) begin
            for (int j = 0; j < N_OUT; j++)
                for (int i = 0; i < N_IN; i++)
                    if (wn_ext == 32'(j) && wi_ext == 32'(i)) w_q[j][i] <= bus.wr_data_i;
        end
    end

    // Per-neuron input current: sum of weights on active spike lines.
    always_comb begin
        cur = '0;
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++)
                if (bus.spike_i[i]) cur[j] = cur[j] + CUR_W'(w_q[j][i]);
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
        lif_neuron #(
            .POT_W(POT_W), .CNT_W(CNT_W), .CUR_W(CUR_W), .LEAK_SHIFT(LEAK_SHIFT),
            .THRESHOLD(THRESHOLD), .THR_INC(THR_INC), .THR_DEC(THR_DEC), .THR_MIN(THR_MIN)
        ) u_neuron (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (clear),
            .en_i    (neuron_en),
            .cur_i   (cur[j]),
            .spike_o (spk[j]),
            .count_o (cnt[j])
        );
    end

    // Window counter, scan index and running best; strict > keeps the lowest index on ties.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_cnt_q  <= '0;
            scan_idx_q <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
        end else if (clear) begin
            win_cnt_q  <= '0;
            scan_idx_q <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
        end else begin
            if (state_q == ST_RUN) win_cnt_q <= win_cnt_q + 1'b1;
            if (state_q == ST_ARGMAX) begin
                scan_idx_q <= scan_idx_q + 1'b1;
                if (cnt[scan_idx_q] > best_cnt_q) begin
                    best_idx_q <= scan_idx_q;
                    best_cnt_q <= cnt[scan_idx_q];
                end
            end
        end
    end

    assign bus.busy_o         = busy;
    assign bus.spike_o        = spk;
    assign bus.result_valid_o = valid;
    assign bus.class_o        = best_idx_q;
    assign bus.max_count_o    = best_cnt_q;

endmodule

// File: tb/tb_snn_window_classifier.sv
// Self-checking bench: table of weight/spike patterns, scoreboard of expected results.
module tb_snn_window_classifier;
    localparam int N_IN  = 8;
    localparam int N_OUT = 10;
    localparam int W_W   = 3;
    localparam int WIN_A = 64;
    localparam int CNT_A = 8;
    localparam int WIN_B = 40;
    localparam int CNT_B = 4;

    typedef struct {
        string      name;
        int         row;
        int         wval;
        logic [7:0] pa;
        logic [7:0] pb;
        int         exp_class;
    } vec_t;

    typedef struct {
        int cls;
        int mc;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snn_window_classifier_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W), .CNT_W(CNT_A)) ifa ();
    snn_window_classifier_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W), .CNT_W(CNT_B)) ifb ();

    snn_window_classifier #(.N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W), .CNT_W(CNT_A), .WIN_LEN(WIN_A))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
    snn_window_classifier #(.N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W), .CNT_W(CNT_B), .WIN_LEN(WIN_B))
        dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

    bit         sel = 1'b0;
    logic       start = 1'b0, wr_en = 1'b0;
    logic [7:0] spk = '0;
    logic [3:0] wn = '0;
    logic [2:0] wi = '0, wd = '0;

    assign ifa.start_i     = start & ~sel;
    assign ifb.start_i     = start & sel;
    assign ifa.wr_en_i     = wr_en & ~sel;
    assign ifb.wr_en_i     = wr_en & sel;
    assign ifa.spike_i     = spk;
    assign ifb.spike_i     = spk;
    assign ifa.wr_neuron_i = wn;
    assign ifb.wr_neuron_i = wn;
    assign ifa.wr_input_i  = wi;
    assign ifb.wr_input_i  = wi;
    assign ifa.wr_data_i   = wd;
    assign ifb.wr_data_i   = wd;

    logic             busy_m, vld_m;
    logic [N_OUT-1:0] spk_m;
    logic [3:0]       cls_m;
    logic [7:0]       mc_m;

    always_comb begin
        if (sel) begin
            busy_m = ifb.busy_o; vld_m = ifb.result_valid_o; spk_m = ifb.spike_o;
            cls_m = ifb.class_o; mc_m = {4'b0, ifb.max_count_o};
        end else begin
            busy_m = ifa.busy_o; vld_m = ifa.result_valid_o; spk_m = ifa.spike_o;
            cls_m = ifa.class_o; mc_m = ifa.max_count_o;
        end
    end

    int wa[N_OUT][N_IN];
    int wb[N_OUT][N_IN];
    res_t             exp_res[$];
    logic [N_OUT-1:0] exp_spk[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic write_w(input bit s, input int n, input int i, input int d);
        sel = s; wr_en = 1'b1; wn = 4'(n); wi = 3'(i); wd = 3'(d);
        @(negedge clk);
        wr_en = 1'b0;
        if (n < N_OUT) begin
            if (s) wb[n][i] = d;
            else   wa[n][i] = d;
        end
    endtask

    task automatic load_row(input bit s, input int row, input int wval);
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++)
                write_w(s, j, i, (j == row) ? wval : 0);
    endtask

    // Behavioural neuron bank over one window; queues per-cycle fires, returns the winner.
    task automatic model(input bit s, input logic [7:0] pa, input logic [7:0] pb,
                         output int cls, output int mc);
        int v[N_OUT];
        int thr[N_OUT];
        int cnt[N_OUT];
        int wl, cmax, cur, vn;
        logic [7:0] sp;
        logic [N_OUT-1:0] f;
        wl   = s ? WIN_B : WIN_A;
        cmax = s ? ((1 << CNT_B) - 1) : ((1 << CNT_A) - 1);
        for (int j = 0; j < N_OUT; j++) begin v[j] = 0; thr[j] = 16; cnt[j] = 0; end
        for (int t = 1; t <= wl; t++) begin
            sp = (t % 2 == 1) ? pa : pb;
            f  = '0;
            for (int j = 0; j < N_OUT; j++) begin
                cur = 0;
                for (int i = 0; i < N_IN; i++)
                    if (sp[i]) cur += s ? wb[j][i] : wa[j][i];
                vn = v[j] - (v[j] >> 3) + cur;
                if (vn > 255) vn = 255;
                if (vn >= thr[j]) begin
                    f[j]   = 1'b1;
                    v[j]   = 0;
                    thr[j] = (thr[j] + 4 > 255) ? 255 : thr[j] + 4;
                    if (cnt[j] < cmax) cnt[j]++;
                end else begin
                    v[j]   = vn;
                    thr[j] = (thr[j] - 2 < 8) ? 8 : thr[j] - 2;
                end
            end
            exp_spk.push_back(f);
        end
        cls = 0; mc = 0;
        for (int j = 0; j < N_OUT; j++)
            if (cnt[j] > mc) begin mc = cnt[j]; cls = j; end
    endtask

    // One full window: optional same-cycle write, optional writes/starts while busy.
    task automatic run_window(input string name, input bit s, input logic [7:0] pa,
                              input logic [7:0] pb, input int exp_class, input bit same_wr,
                              input int swn, input int swi, input int swd, input bit junk);
        int wl, last, spk_err, busy_err, vld_err, seen, mcls, mmc;
        res_t e, r;
        logic [N_OUT-1:0] es;
        wl = s ? WIN_B : WIN_A;
        last = wl + N_OUT + 1;
        spk_err = 0; busy_err = 0; vld_err = 0; seen = 0;
        sel = s;
        if (same_wr) begin
            wr_en = 1'b1; wn = 4'(swn); wi = 3'(swi); wd = 3'(swd);
            if (s) wb[swn][swi] = swd;
            else   wa[swn][swi] = swd;
        end
        start = 1'b1;
        model(s, pa, pb, mcls, mmc);
        e.cls = (exp_class >= 0) ? exp_class : mcls;
        e.mc  = mmc;
        exp_res.push_back(e);
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        for (int c = 1; c <= last + 3; c++) begin
            es = (c >= 2 && c <= wl + 1 && exp_spk.size() > 0) ? exp_spk.pop_front() : '0;
            if (spk_m !== es) spk_err++;
            if (busy_m !== (c <= wl + N_OUT)) busy_err++;
            if (vld_m !== (c == last)) vld_err++;
            if (vld_m === 1'b1 && exp_res.size() > 0) begin
                r = exp_res.pop_front();
                check({name, "_class"}, int'(cls_m), r.cls);
                check({name, "_max_count"}, int'(mc_m), r.mc);
                seen++;
            end
            spk = (c <= wl) ? ((c % 2 == 1) ? pa : pb) : 8'h00;
            if (junk) begin
                wr_en = (c == 10) || (c == wl + 3);
                wn = 4'd5; wi = 3'd0; wd = 3'd7;
                start = (c == 20) || (c == wl + 5);
            end
            @(negedge clk);
        end
        start = 1'b0; wr_en = 1'b0;
        check({name, "_spike_trace_errs"}, spk_err, 0);
        check({name, "_busy_errs"}, busy_err, 0);
        check({name, "_valid_errs"}, vld_err, 0);
        check({name, "_results_seen"}, seen, 1);
        check({name, "_class_hold"}, int'(cls_m), e.cls);
        exp_res.delete();
        exp_spk.delete();
    endtask

    vec_t vecs[6];

    initial begin
        int err_b, err_v, err_s, err_c, vld_cnt;
        vecs[0] = '{"row2_w7_in0",   2, 7, 8'h01, 8'h01, 2};
        vecs[1] = '{"row5_w1_all",   5, 1, 8'hFF, 8'hFF, 5};
        vecs[2] = '{"row9_w3_alt",   9, 3, 8'hAA, 8'h55, 9};
        vecs[3] = '{"all_zero_w",    0, 0, 8'hFF, 8'hFF, 0};
        vecs[4] = '{"row7_w2_in7",   7, 2, 8'h80, 8'h80, 7};
        vecs[5] = '{"row3_no_spike", 3, 7, 8'h00, 8'h00, 0};
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++) begin wa[j][i] = 0; wb[j][i] = 0; end

        // Reset, then idle: everything quiet on both instances.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        err_b = 0; err_v = 0; err_s = 0; err_c = 0;
        repeat (5) begin
            @(negedge clk);
            if (ifa.busy_o !== 1'b0 || ifb.busy_o !== 1'b0) err_b++;
            if (ifa.result_valid_o !== 1'b0 || ifb.result_valid_o !== 1'b0) err_v++;
            if (ifa.spike_o !== '0 || ifb.spike_o !== '0) err_s++;
            if (ifa.class_o !== '0 || ifa.max_count_o !== '0 ||
                ifb.class_o !== '0 || ifb.max_count_o !== '0) err_c++;
        end
        check("idle_busy", err_b, 0);
        check("idle_valid", err_v, 0);
        check("idle_spike", err_s, 0);
        check("idle_result", err_c, 0);

        // Table of weight rows and spike patterns.
        foreach (vecs[k]) begin
            load_row(0, vecs[k].row, vecs[k].wval);
            run_window(vecs[k].name, 0, vecs[k].pa, vecs[k].pb, vecs[k].exp_class, 0, 0, 0, 0, 0);
        end

        // Writes and starts while busy are dropped.
        load_row(0, 2, 7);
        run_window("reference", 0, 8'h01, 8'h01, 2, 0, 0, 0, 0, 0);
        run_window("junk_while_busy", 0, 8'h01, 8'h01, -1, 0, 0, 0, 0, 1);
        run_window("after_junk", 0, 8'h01, 8'h01, 2, 0, 0, 0, 0, 0);

        // Out-of-range neuron address is ignored; same-cycle write+start is used at once.
        write_w(0, 12, 0, 7);
        write_w(0, 15, 3, 7);
        run_window("wr_with_start", 0, 8'h01, 8'h01, 1, 1, 1, 0, 7, 0);

        // Narrow counters saturate; all neurons tie so the lowest index wins.
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++) write_w(1, j, i, 7);
        run_window("cnt4_saturate", 1, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of RUN aborts without a result.
        sel = 1'b0;
        load_row(0, 2, 7);
        spk = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_rst", int'(ifa.busy_o), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", int'(ifa.busy_o), 0);
        check("rst_spike", int'(ifa.spike_o), 0);
        check("rst_class", int'(ifa.class_o), 0);
        vld_cnt = 0;
        repeat (WIN_A + N_OUT + 5) begin
            @(negedge clk);
            if (ifa.result_valid_o === 1'b1 || ifa.busy_o === 1'b1) vld_cnt++;
        end
        check("no_activity_after_rst", vld_cnt, 0);
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++) begin wa[j][i] = 0; wb[j][i] = 0; end
        run_window("weights_zero_after_rst", 0, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
